// File: rtl/multi_debouncer_pkg.sv
// Shared definitions for the input-conditioning blocks: default timing values,
// the auto-repeat phase type and the width helpers used to size counters.
package multi_debouncer_pkg;

    localparam int DEF_N_CH   = 4;
    localparam int DEF_DELAY  = 40;
    localparam int DEF_HOLD   = 1000;
    localparam int DEF_PERIOD = 200;

    // Auto-repeat waits HOLD cycles for the first pulse, then PERIOD for the rest.
    typedef enum logic {
        RPT_HOLD   = 1'b0,
        RPT_PERIOD = 1'b1
    } rpt_phase_t;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input: 2-flop synchroniser, stability-window debounce,
// registered press/release pulses and optional auto-repeat.
module debounce_channel
    import multi_debouncer_pkg::*;
#(
    parameter int DELAY     = DEF_DELAY,
    parameter int REPEAT_EN = 0,
    parameter int HOLD      = DEF_HOLD,
    parameter int PERIOD    = DEF_PERIOD,
    parameter int CNT_W     = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam bit               RPT_ON      = (REPEAT_EN != 0);
    localparam logic [CNT_W-1:0] DCNT_LAST   = CNT_W'(DELAY - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD - 1);

    logic             s1_reg, s2_reg;
    logic             cand_reg, cand_next;
    logic             level_reg, level_next;
    logic             press_reg, press_next;
    logic             rel_reg, rel_next;
    logic             rpt_reg, rpt_next;
    logic [CNT_W-1:0] dcnt_reg, dcnt_next;
    logic [CNT_W-1:0] hcnt_reg, hcnt_next;
    logic [CNT_W-1:0] hcnt_target;
    rpt_phase_t       phase_reg, phase_next;

    // Debounce: any disagreement with the candidate restarts the window.
    always_comb begin
        cand_next  = cand_reg;
        dcnt_next  = dcnt_reg;
        level_next = level_reg;
        press_next = 1'b0;
        rel_next   = 1'b0;
        if (s2_reg != cand_reg) begin
            cand_next = s2_reg;
            dcnt_next = '0;
        end else if (cand_reg != level_reg) begin
            if (dcnt_reg == DCNT_LAST) begin
                level_next = cand_reg;
                dcnt_next  = '0;
                press_next = cand_reg;
                rel_next   = ~cand_reg;
            end else begin
                dcnt_next = dcnt_reg + 1'b1;
            end
        end else begin
            dcnt_next = '0;
        end
    end

    // Auto-repeat: level is still 0 on the press cycle, so hcnt restarts there too.
    always_comb begin
        hcnt_next   = hcnt_reg;
        phase_next  = phase_reg;
        rpt_next    = 1'b0;
        hcnt_target = (phase_reg == RPT_HOLD) ? HOLD_LAST : PERIOD_LAST;
        if (!RPT_ON || !level_reg || rel_next) begin
            hcnt_next  = '0;
            phase_next = RPT_HOLD;
        end else if (hcnt_reg == hcnt_target) begin
            rpt_next   = 1'b1;
            hcnt_next  = '0;
            phase_next = RPT_PERIOD;
        end else begin
            hcnt_next = hcnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg    <= 1'b0;
            s2_reg    <= 1'b0;
            cand_reg  <= 1'b0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
            rel_reg   <= 1'b0;
            rpt_reg   <= 1'b0;
            dcnt_reg  <= '0;
            hcnt_reg  <= '0;
            phase_reg <= RPT_HOLD;
        end else begin
            s1_reg    <= in;
            s2_reg    <= s1_reg;
            cand_reg  <= cand_next;
            level_reg <= level_next;
            press_reg <= press_next;
            rel_reg   <= rel_next;
            rpt_reg   <= rpt_next;
            dcnt_reg  <= dcnt_next;
            hcnt_reg  <= hcnt_next;
            phase_reg <= phase_next;
        end
    end

    assign level         = level_reg;
    assign press         = press_reg;
    assign release_pulse = rel_reg;
    assign repeat_pulse  = rpt_reg;

endmodule

// File: rtl/multi_debouncer.sv
// N independent debounce channels sharing one clock; counter width is derived
// from the largest of the timing parameters.
module multi_debouncer
    import multi_debouncer_pkg::*;
#(
    parameter int N_CH      = DEF_N_CH,
    parameter int DELAY     = DEF_DELAY,
    parameter int REPEAT_EN = 0,
    parameter int HOLD      = DEF_HOLD,
    parameter int PERIOD    = DEF_PERIOD
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] repeat_pulse
);

    localparam int CNT_W = clog2(max3(DELAY, HOLD, PERIOD) + 1);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            debounce_channel #(
                .DELAY     (DELAY),
                .REPEAT_EN (REPEAT_EN),
                .HOLD      (HOLD),
                .PERIOD    (PERIOD),
                .CNT_W     (CNT_W)
            ) u_ch (
                .clk           (clk),
                .rst_n         (rst_n),
                .in            (in[gi]),
                .level         (level[gi]),
                .press         (press[gi]),
                .release_pulse (release_pulse[gi]),
                .repeat_pulse  (repeat_pulse[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_debouncer.sv
// Randomised and directed bench for multi_debouncer against a sample-history model.
module tb_multi_debouncer;

    localparam int N_CH   = 4;
    localparam int DELAY  = 4;
    localparam int HOLD   = 6;
    localparam int PERIOD = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_CH-1:0] in_v = '0;
    logic [N_CH-1:0] level, press, rel, rpt;

    always #5 clk = ~clk;

    multi_debouncer #(
        .N_CH(N_CH), .DELAY(DELAY), .REPEAT_EN(1), .HOLD(HOLD), .PERIOD(PERIOD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in(in_v), .level(level), .press(press),
        .release_pulse(rel), .repeat_pulse(rpt)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: each channel keeps its last DELAY+1 synchronised samples; the level
    // flips when they all agree on the opposite value. Repeat timing is derived
    // from the number of cycles since the press.
    logic [N_CH-1:0] m_s1, m_s2;
    bit              hist [N_CH][$];
    int              since_press [N_CH];
    logic [N_CH-1:0] e_level, e_press, e_rel, e_rpt;

    task automatic model_step();
        bit stable;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0;
            e_level = '0; e_press = '0; e_rel = '0; e_rpt = '0;
            for (int ch = 0; ch < N_CH; ch++) begin
                hist[ch].delete();
                since_press[ch] = 0;
            end
        end else begin
            e_press = '0; e_rel = '0; e_rpt = '0;
            for (int ch = 0; ch < N_CH; ch++) begin
                hist[ch].push_back(m_s2[ch]);
                if (hist[ch].size() > DELAY + 1) void'(hist[ch].pop_front());
                stable = (hist[ch].size() == DELAY + 1);
                for (int i = 0; i < hist[ch].size(); i++)
                    if (hist[ch][i] != hist[ch][0]) stable = 1'b0;
                if (stable && hist[ch][0] != e_level[ch]) begin
                    e_level[ch] = hist[ch][0];
                    if (hist[ch][0]) begin
                        e_press[ch] = 1'b1;
                        since_press[ch] = 0;
                    end else begin
                        e_rel[ch] = 1'b1;
                    end
                end else if (e_level[ch]) begin
                    since_press[ch]++;
                    if (since_press[ch] >= HOLD && (since_press[ch] - HOLD) % PERIOD == 0)
                        e_rpt[ch] = 1'b1;
                end
            end
            m_s2 = m_s1;
            m_s1 = in_v;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_v  = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({level, press, rel, rpt} !== 16'h0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: got %h want 0000", cyc, {level, press, rel, rpt});
            end
        end
        rst_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            checks++;
            if (level !== ((j >= DELAY + 2) ? 4'hF : 4'h0) || press !== ((j == DELAY + 2) ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL reset_release edge %0d: level %h press %h", j, level, press);
            end
            checks++;
            if ({level, press, rel, rpt} !== {e_level, e_press, e_rel, e_rpt}) begin
                errors++;
                $display("FAIL reset_model cyc %0d: got %h want %h", cyc, {level, press, rel, rpt}, {e_level, e_press, e_rel, e_rpt});
            end
        end
    endtask

    task automatic test_bounce();
        int press_at, n_press, n_rel;
        in_v = '0;
        for (int i = 0; i < 12; i++) tick();
        n_press = 0; n_rel = 0; press_at = -1;
        in_v[0] = 1'b1; tick();
        in_v[0] = 1'b0; tick();
        in_v[0] = 1'b1; tick();
        in_v[0] = 1'b0; tick();
        in_v[0] = 1'b1;
        for (int j = 0; j < 15; j++) begin
            tick();
            if (press[0]) begin n_press++; press_at = j; end
            if (rel[0]) n_rel++;
            checks++;
            if ({level, press, rel, rpt} !== {e_level, e_press, e_rel, e_rpt}) begin
                errors++;
                $display("FAIL bounce_model cyc %0d: got %h want %h", cyc, {level, press, rel, rpt}, {e_level, e_press, e_rel, e_rpt});
            end
        end
        checks++;
        if (n_press != 1 || press_at != DELAY + 2 || n_rel != 0) begin
            errors++;
            $display("FAIL bounce_press: presses %0d at %0d releases %0d, want 1 at %0d and 0", n_press, press_at, n_rel, DELAY + 2);
        end
    endtask

    task automatic test_glitch();
        int seen;
        seen = 0;
        in_v[1] = 1'b1;
        for (int j = 0; j < 16; j++) begin
            if (j == DELAY) in_v[1] = 1'b0;
            tick();
            if (level[1] || press[1] || rel[1]) seen++;
            checks++;
            if ({level, press, rel, rpt} !== {e_level, e_press, e_rel, e_rpt}) begin
                errors++;
                $display("FAIL glitch_model cyc %0d: got %h want %h", cyc, {level, press, rel, rpt}, {e_level, e_press, e_rel, e_rpt});
            end
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL glitch_reject: ch1 activity on %0d cycles, want 0", seen);
        end
    endtask

    task automatic test_release();
        int n, rel_at, n_rel;
        in_v[2] = 1'b1;
        for (n = 0; n < 30 && !level[2]; n++) tick();
        checks++;
        if (!level[2]) begin
            errors++;
            $display("FAIL release_setup: level[2] got 0 want 1 within 30 cycles");
        end
        in_v[2] = 1'b0;
        rel_at = -1; n_rel = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (rel[2]) begin n_rel++; rel_at = j; end
            checks++;
            if ({level, press, rel, rpt} !== {e_level, e_press, e_rel, e_rpt}) begin
                errors++;
                $display("FAIL release_model cyc %0d: got %h want %h", cyc, {level, press, rel, rpt}, {e_level, e_press, e_rel, e_rpt});
            end
        end
        checks++;
        if (n_rel != 1 || rel_at != DELAY + 2 || level[2] !== 1'b0) begin
            errors++;
            $display("FAIL release_pulse: releases %0d at %0d level %b, want 1 at %0d level 0", n_rel, rel_at, level[2], DELAY + 2);
        end
    endtask

    task automatic test_repeat();
        int n;
        bit want;
        in_v[3] = 1'b1;
        for (n = 0; n < 30 && !press[3]; n++) tick();
        checks++;
        if (!press[3]) begin
            errors++;
            $display("FAIL repeat_setup: press[3] got 0 want 1 within 30 cycles");
        end
        for (int c = 1; c <= 20; c++) begin
            tick();
            want = (c >= HOLD) && ((c - HOLD) % PERIOD == 0);
            checks++;
            if (rpt[3] !== want || press[3] !== 1'b0) begin
                errors++;
                $display("FAIL repeat_timing +%0d: repeat %b press %b, want repeat %b press 0", c, rpt[3], press[3], want);
            end
            checks++;
            if ({level, press, rel, rpt} !== {e_level, e_press, e_rel, e_rpt}) begin
                errors++;
                $display("FAIL repeat_model cyc %0d: got %h want %h", cyc, {level, press, rel, rpt}, {e_level, e_press, e_rel, e_rpt});
            end
        end
        in_v[3] = 1'b0;
        for (n = 0; n < 30 && !rel[3]; n++) tick();
        checks++;
        if (!rel[3] || rpt[3]) begin
            errors++;
            $display("FAIL repeat_release: release %b repeat %b, want 1 and 0", rel[3], rpt[3]);
        end
        n = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (rpt[3]) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL repeat_after_release: %0d repeat pulses, want 0", n);
        end
    endtask

    task automatic test_reset_mid();
        in_v = 4'b0001;
        for (int i = 0; i < 12; i++) tick();
        in_v[1] = 1'b1;
        for (int i = 0; i < DELAY + 1; i++) tick();
        rst_n = 1'b0;
        model_step();
        #1;
        checks++;
        if ({level, press, rel, rpt} !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_async: got %h want 0000", {level, press, rel, rpt});
        end
        tick(); tick();
        rst_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            checks++;
            if (level !== ((j >= DELAY + 2) ? 4'b0011 : 4'b0000)) begin
                errors++;
                $display("FAIL reset_mid_restart edge %0d: level %b want %b", j, level, (j >= DELAY + 2) ? 4'b0011 : 4'b0000);
            end
            checks++;
            if ({level, press, rel, rpt} !== {e_level, e_press, e_rel, e_rpt}) begin
                errors++;
                $display("FAIL reset_mid_model cyc %0d: got %h want %h", cyc, {level, press, rel, rpt}, {e_level, e_press, e_rel, e_rpt});
            end
        end
    endtask

    task automatic test_random();
        int hold_left [N_CH];
        for (int ch = 0; ch < N_CH; ch++) hold_left[ch] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (hold_left[ch] == 0) begin
                    in_v[ch] = 1'($urandom_range(0, 1));
                    hold_left[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30))
                                                                 : int'($urandom_range(1, 7));
                end
                hold_left[ch]--;
            end
            tick();
            checks++;
            if ({level, press, rel, rpt} !== {e_level, e_press, e_rel, e_rpt}) begin
                errors++;
                $display("FAIL random_model cyc %0d: got %h want %h", cyc, {level, press, rel, rpt}, {e_level, e_press, e_rel, e_rpt});
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_glitch();
        test_release();
        test_repeat();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
